// File: rtl/register_4bit.sv
// Parallel-load shift/rotate register: clear > load > shift > hold, async active-low reset.
// Each bit is a small cell; the top only routes neighbour bits and end-of-register fills.

module register_4bit_cell #(
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic shift_en,
   input  logic shift_dir,
   input  logic d,
   input  logic from_hi,
   input  logic from_lo,
   output logic q
);

   // shift_dir=0 pulls from the higher neighbour, shift_dir=1 from the lower one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          q <= RST_BIT;
      else if (clr)      q <= 1'b0;
      else if (load)     q <= d;
      else if (shift_en) q <= shift_dir ? from_lo : from_hi;
   end

endmodule

module register_4bit #(
   parameter int                 WIDTH       = 4,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             shift_dir,
   input  logic             rotate,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out
);

   logic             fill_r;
   logic             fill_l;
   logic [WIDTH-1:0] hi_src;
   logic [WIDTH-1:0] lo_src;

   // vacated end bit: wrapped-around bit when rotating, serial_in otherwise
   assign fill_r     = rotate ? q[0]       : serial_in;
   assign fill_l     = rotate ? q[WIDTH-1] : serial_in;
   assign serial_out = shift_dir ? q[WIDTH-1] : q[0];

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         if (i == WIDTH-1) begin : g_msb
            assign hi_src[i] = fill_r;
         end else begin : g_mid_hi
            assign hi_src[i] = q[i+1];
         end
         if (i == 0) begin : g_lsb
            assign lo_src[i] = fill_l;
         end else begin : g_mid_lo
            assign lo_src[i] = q[i-1];
         end

         register_4bit_cell #(
            .RST_BIT (RESET_VALUE[i])
         ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .load      (load),
            .shift_en  (shift_en),
            .shift_dir (shift_dir),
            .d         (d[i]),
            .from_hi   (hi_src[i]),
            .from_lo   (lo_src[i]),
            .q         (q[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_register_4bit.sv
// Directed bench for register_4bit: default 4-bit instance plus an 8-bit instance
// with a non-zero reset value sharing the same controls.

module tb_register_4bit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic       clr = 1'b0;
   logic       shift_en = 1'b0;
   logic       shift_dir = 1'b0;
   logic       rotate = 1'b0;
   logic       serial_in = 1'b0;
   logic [3:0] d = 4'b0000;
   logic [7:0] d8 = 8'h00;
   logic [3:0] q;
   logic [7:0] q8;
   logic       so;
   logic       so8;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   register_4bit dut (
      .clk(clk), .rst(rst), .load(load), .d(d), .clr(clr), .shift_en(shift_en),
      .shift_dir(shift_dir), .rotate(rotate), .serial_in(serial_in),
      .q(q), .serial_out(so)
   );

   register_4bit #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
      .clk(clk), .rst(rst), .load(load), .d(d8), .clr(clr), .shift_en(shift_en),
      .shift_dir(shift_dir), .rotate(rotate), .serial_in(serial_in),
      .q(q8), .serial_out(so8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      load = 0; clr = 0; shift_en = 0; shift_dir = 0; rotate = 0; serial_in = 0;
   endtask

   task automatic test_reset();
      int errs;
      errs = 0;
      rst = 0; load = 0; d = 4'b0000;
      clr = 1'bx; shift_en = 1'bx; rotate = 1'bx; serial_in = 1'bx; shift_dir = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (q !== 4'b0000) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL reset_hold q=%b want 0000 (%0d samples)", q, errs); end
      total++;
      if (q8 !== 8'hA5) begin bad++; $display("FAIL reset_value8 q8=%h want a5", q8); end
      total++;
      if (so !== 1'b0) begin bad++; $display("FAIL reset_serial_out so=%b want 0", so); end
      total++;
      if (so8 !== 1'b1) begin bad++; $display("FAIL reset_serial_out8 so8=%b want 1", so8); end
      idle();
      rst = 1;
   endtask

   task automatic test_load_hold();
      load = 1; d = 4'b1010; tick();
      total++;
      if (q !== 4'b1010) begin bad++; $display("FAIL load1 q=%b want 1010", q); end
      load = 0; d = 4'b1100; tick();
      total++;
      if (q !== 4'b1010) begin bad++; $display("FAIL hold q=%b want 1010", q); end
      load = 1; tick();
      total++;
      if (q !== 4'b1100) begin bad++; $display("FAIL load2 q=%b want 1100", q); end
      load = 0;
   endtask

   task automatic test_shift();
      shift_en = 1; shift_dir = 0; rotate = 0; serial_in = 1; tick();
      total++;
      if (q !== 4'b1110 || so !== 1'b0) begin bad++; $display("FAIL shift_right q=%b so=%b want 1110/0", q, so); end
      shift_dir = 1; serial_in = 0; tick();
      total++;
      if (q !== 4'b1100 || so !== 1'b1) begin bad++; $display("FAIL shift_left q=%b so=%b want 1100/1", q, so); end
      shift_en = 0; shift_dir = 0; #1;
      total++;
      if (so !== 1'b0) begin bad++; $display("FAIL serial_out_dir so=%b want 0", so); end
   endtask

   task automatic test_rotate();
      load = 1; d = 4'b1010; tick();
      load = 0; shift_en = 1; rotate = 1; shift_dir = 1; serial_in = 0; tick();
      total++;
      if (q !== 4'b0101) begin bad++; $display("FAIL rotate_left q=%b want 0101", q); end
      shift_dir = 0; serial_in = 0; tick();
      total++;
      if (q !== 4'b1010) begin bad++; $display("FAIL rotate_right q=%b want 1010", q); end
      load = 1; d = 4'b0001; shift_en = 0; tick();
      load = 0; shift_en = 1; shift_dir = 0; serial_in = 0; tick();
      total++;
      if (q !== 4'b1000) begin bad++; $display("FAIL rotate_wrap q=%b want 1000", q); end
      idle();
   endtask

   task automatic test_clr_priority();
      load = 1; d = 4'b1111; tick();
      clr = 1; load = 1; d = 4'b0110; shift_en = 1; tick();
      total++;
      if (q !== 4'b0000) begin bad++; $display("FAIL clr_priority q=%b want 0000", q); end
      clr = 0; tick();
      total++;
      if (q !== 4'b0110) begin bad++; $display("FAIL load_over_shift q=%b want 0110", q); end
      idle();
   endtask

   task automatic test_ignore_when_idle();
      rotate = 1; shift_dir = 1; serial_in = 1; d = 4'b1001; tick();
      d = 4'b0011; tick();
      total++;
      if (q !== 4'b0110) begin bad++; $display("FAIL idle_hold q=%b want 0110", q); end
      idle();
   endtask

   task automatic test_wide();
      load = 1; d8 = 8'h3C; tick();
      load = 0; shift_en = 1; shift_dir = 1; rotate = 0; serial_in = 1; tick();
      total++;
      if (q8 !== 8'h79) begin bad++; $display("FAIL wide_shift_left q8=%h want 79", q8); end
      shift_dir = 0; rotate = 1; serial_in = 0; tick();
      total++;
      if (q8 !== 8'hBC || so8 !== 1'b0) begin bad++; $display("FAIL wide_rotate_right q8=%h so8=%b want bc/0", q8, so8); end
      idle();
   endtask

   task automatic test_async_reset();
      load = 1; d = 4'b1011; tick();
      total++;
      if (q !== 4'b1011) begin bad++; $display("FAIL pre_reset_load q=%b want 1011", q); end
      load = 0; shift_en = 1; shift_dir = 0; serial_in = 1;
      #2 rst = 0;
      #1;
      total++;
      if (q !== 4'b0000 || so !== 1'b0) begin bad++; $display("FAIL async_reset q=%b so=%b want 0000/0", q, so); end
      total++;
      if (q8 !== 8'hA5) begin bad++; $display("FAIL async_reset8 q8=%h want a5", q8); end
      @(negedge clk);
      idle();
      rst = 1;
      tick();
      tick();
      total++;
      if (q !== 4'b0000) begin bad++; $display("FAIL post_reset_hold q=%b want 0000", q); end
   endtask

   initial begin
      test_reset();
      test_load_hold();
      test_shift();
      test_rotate();
      test_clr_priority();
      test_ignore_when_idle();
      test_wide();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
